// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the two-master MIPS memory-bus arbiter.
package mips_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GNT_I,
        ST_GNT_D,
        ST_ERR_I,
        ST_ERR_D
    } arb_state_e;

    localparam logic [31:0] MEM_BASE_DEF = 32'hBFC00000;
    localparam logic [31:0] MEM_SIZE_DEF = 32'h00008000;
    localparam logic [3:0]  BE_WORD      = 4'hF;

    // A master that wins arbitration goes to its grant or error state
    // depending on whether its address falls inside the RAM window.
    function automatic arb_state_e grant_of(input logic is_d, input logic in_range);
        if (is_d) return in_range ? ST_GNT_D : ST_ERR_D;
        return in_range ? ST_GNT_I : ST_ERR_I;
    endfunction

endpackage

// File: rtl/mips_bus_range_chk.sv
// Combinational RAM-window check; the subtraction wraps, so addresses
// below BASE fall out of range with a single unsigned compare.
module mips_bus_range_chk #(
    parameter logic [31:0] BASE = 32'hBFC00000,
    parameter logic [31:0] SIZE = 32'h00008000
) (
    input  logic [31:0] addr_i,
    output logic        in_range_o
);

    logic [31:0] offset;

    assign offset     = addr_i - BASE;
    assign in_range_o = (addr_i != 32'h0) && (offset < SIZE);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master (fetch / load-store) arbiter for the single MIPS memory bus.
// All bus and master-side outputs are decoded from the registered state.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter logic [31:0] MEM_BASE   = MEM_BASE_DEF,
    parameter logic [31:0] MEM_SIZE   = MEM_SIZE_DEF,
    parameter bit          D_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic [31:0] i_readdata,
    output logic        i_waitrequest,

    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic [31:0] d_readdata,
    output logic        d_waitrequest,

    output logic        addr_err,

    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    arb_state_e state_q, state_d;
    logic       i_req, d_req;
    logic       i_ok, d_ok;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    mips_bus_range_chk #(.BASE(MEM_BASE), .SIZE(MEM_SIZE)) u_chk_i (
        .addr_i     (i_address),
        .in_range_o (i_ok)
    );

    mips_bus_range_chk #(.BASE(MEM_BASE), .SIZE(MEM_SIZE)) u_chk_d (
        .addr_i     (d_address),
        .in_range_o (d_ok)
    );

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        address       = 32'h0;
        read          = 1'b0;
        write         = 1'b0;
        writedata     = 32'h0;
        byteenable    = 4'h0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        i_readdata    = 32'h0;
        d_readdata    = 32'h0;
        addr_err      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (d_req && (D_PRIORITY || !i_req)) state_d = grant_of(1'b1, d_ok);
                else if (i_req)                      state_d = grant_of(1'b0, i_ok);
            end
            // On completion the served master still holds its request, so only
            // the other master is considered for the hand-over.
            ST_GNT_I: begin
                read          = 1'b1;
                address       = i_address;
                byteenable    = BE_WORD;
                i_waitrequest = waitrequest;
                i_readdata    = readdata;
                if (!waitrequest) state_d = d_req ? grant_of(1'b1, d_ok) : ST_IDLE;
            end
            ST_GNT_D: begin
                read          = d_read & ~d_write;
                write         = d_write;
                address       = d_address;
                writedata     = d_writedata;
                byteenable    = d_byteenable;
                d_waitrequest = waitrequest;
                d_readdata    = readdata;
                if (!waitrequest) state_d = i_req ? grant_of(1'b0, i_ok) : ST_IDLE;
            end
            ST_ERR_I: begin
                i_waitrequest = 1'b0;
                addr_err      = 1'b1;
                state_d       = ST_IDLE;
            end
            ST_ERR_D: begin
                d_waitrequest = 1'b0;
                addr_err      = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
